ysyx_22041752_regfile_mp: RTL and testbench
===========================================

// Module: ysyx_22041752_regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with an integrated busy
//  scoreboard. Successor to the fixed 64x32 two-read/one-write file.
//  Adds NRD read ports, NWP write ports, optional same-cycle write-to-read
//  bypass, synchronous reset of all state, and per-register busy bits.
//  Sits between decode/issue (reads, alloc) and writeback (writes).
// PARAMETERS
//  XLEN    64  data width of each register
//  NREG    32  register count, power of 2, >=2; entry 0 reads 0 always
//  NRD     2   number of combinational read ports, 1..4
//  NWP     2   number of write ports, 1..2; higher index has priority
//  BYPASS  1   1: a read sees a same-cycle write; 0: a read sees array contents
//  AW      $clog2(NREG)  address width (derived; do not override)
// PORTS
//  clk         in   1         clock, all state updates on posedge
//  rst_n       in   1         synchronous active-low reset
//  raddr       in   NRD*AW    read addresses, port j at [j*AW +: AW]
//  rdata       out  NRD*XLEN  read data, port j at [j*XLEN +: XLEN]
//  rbusy       out  NRD       busy bit of each read address (after bypass)
//  we          in   NWP       write enables
//  waddr       in   NWP*AW    write addresses
//  wdata       in   NWP*XLEN  write data
//  alloc_en    in   1         issue marks alloc_addr as having a pending producer
//  alloc_addr  in   AW        destination being allocated
//  alloc_waw   out  1         busy[alloc_addr] & alloc_en (WAW hazard flag)
// BEHAVIOUR
//  Reset: posedge with rst_n=0 clears all regs[i] and busy[i] to 0.
//   we and alloc_en are ignored in that cycle. While rst_n=0, bypass and
//   rbusy are suppressed: rdata shows the array, rbusy=0, alloc_waw=0.
//  Write: posedge, we[k] & waddr_k!=0 -> regs[waddr_k]<=wdata_k. Writes to 0
//   are dropped. Two ports writing the same address: port NWP-1 wins.
//  Read: combinational, 0-cycle latency. raddr_j==0 -> rdata_j=0, rbusy_j=0.
//   BYPASS=1 and any we[k] to raddr_j (!=0) -> rdata_j = wdata of the highest
//   such k. Otherwise rdata_j = regs[raddr_j].
//  Busy: posedge, alloc_en & alloc_addr!=0 sets busy[alloc_addr].
//   we[k] to addr a (!=0) clears busy[a].
//   Alloc and write to the same addr in one cycle: set wins (new producer).
//   A write to a non-busy register still updates data; busy stays 0.
//  rbusy_j = busy[raddr_j], except 0 when BYPASS=1 and a same-cycle write
//   targets raddr_j. alloc_waw is informational; the alloc still takes effect.
//  No outputs are registered. Every output is a function of the state and
//   current inputs.
// STRUCTURE
//  Package ysyx_22041752_rf_pkg: default XLEN/NREG, ZERO_REG=0 constant,
//   function for the highest-priority write-hit index.
//  Sub-module ysyx_22041752_rf_bypass: one instance per read port.
//   Takes the array value plus the write buses; returns rdata_j and a hit flag.
//  Top: generate loops for the regs/busy array and the read ports.
// TESTING
//  1 Reset, then read all addrs on every port -> rdata=0, rbusy=0.
//  2 we0 a=5 d=0xDEAD, next cycle raddr0=5 -> 0xDEAD; we0 a=0 d=1 -> raddr=0 gives 0.
//  3 Same cycle we0 a=7 d=1, we1 a=7 d=2 -> next cycle reg7=2;
//    BYPASS=1 same-cycle read of 7 -> 2.
//  4 alloc a=9 -> rbusy=1 on read 9; alloc 9 again -> alloc_waw=1;
//    we a=9 -> read same cycle rbusy=0 (BYPASS=1), busy cleared next cycle.
//  5 alloc a=3 and we a=3 same cycle -> busy[3]=1 after edge, reg3=wdata.
//  6 Set regs/busy, assert rst_n=0 with we/alloc active -> all 0 after edge;
//    repeat with BYPASS=0 and NRD=4, NWP=1.

Source files
------------

// File: rtl/ysyx_22041752_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041752_rf_pkg
//  Purpose  : Shared defaults and helpers for the multi-port register file.
//             Provides the default data width and register count, the
//             hard-wired zero register index, and the function that selects
//             which write port a read port must forward from.
//  Revision : 1.0  initial multi-port release
// ============================================================================
package ysyx_22041752_rf_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int ZERO_REG = 0;
    // Width of the hit vector handed to hit_idx; covers every legal NWP.
    localparam int MAX_WP   = 4;

    // Index of the highest set bit; the highest-numbered write port owns a
    // contested address, so it is also the one a bypassing read must see.
    function automatic logic [1:0] hit_idx(input logic [MAX_WP-1:0] hits);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_WP; k++) begin
            if (hits[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041752_rf_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041752_rf_bypass
//  Purpose  : Read-port data selection. Returns zero for the zero register,
//             otherwise either the stored array value or, when forwarding is
//             enabled, the data of the highest write port targeting raddr.
//  Ports    : en        forwarding allowed this cycle (low during reset)
//             raddr     read address
//             arr_data  array contents at raddr
//             we/waddr/wdata  write buses of all write ports
//             rdata     selected read data
//             hit       a same-cycle write to raddr was forwarded
//  Revision : 1.0  initial multi-port release
// ============================================================================
module ysyx_22041752_rf_bypass
    import ysyx_22041752_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = 5,
    parameter int NWP    = 2,
    parameter int BYPASS = 1
) (
    input  logic                 en,
    input  logic [AW-1:0]        raddr,
    input  logic [XLEN-1:0]      arr_data,
    input  logic [NWP-1:0]       we,
    input  logic [NWP*AW-1:0]    waddr,
    input  logic [NWP*XLEN-1:0]  wdata,
    output logic [XLEN-1:0]      rdata,
    output logic                 hit
);

    logic [MAX_WP-1:0] w_hits;
    logic [1:0]        w_idx;

    always_comb begin
        w_hits = '0;
        for (int k = 0; k < NWP; k++) begin
            w_hits[k] = (BYPASS != 0) && en && we[k]
                        && (raddr != AW'(ZERO_REG))
                        && (waddr[k*AW +: AW] == raddr);
        end
    end

    assign w_idx = hit_idx(w_hits);

    always_comb begin
        rdata = arr_data;
        hit   = |w_hits;
        if (raddr == AW'(ZERO_REG)) begin
            rdata = '0;
        end else begin
            for (int k = 0; k < NWP; k++) begin
                if (w_hits[k] && (w_idx == 2'(k))) begin
                    rdata = wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22041752_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041752_regfile_mp
//  Purpose  : Parametrised multi-port integer register file with per-register
//             busy scoreboard. Entry 0 always reads zero and is never busy.
//  Ports    : clk, rst_n (synchronous, active low)
//             raddr/rdata/rbusy   NRD combinational read ports
//             we/waddr/wdata      NWP write ports, higher index wins
//             alloc_en/alloc_addr mark a destination as pending
//             alloc_waw           allocating a register that is already busy
//  Revision : 1.0  initial multi-port release
// ============================================================================
module ysyx_22041752_regfile_mp
    import ysyx_22041752_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int NWP    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWP-1:0]       we,
    input  logic [NWP*AW-1:0]    waddr,
    input  logic [NWP*XLEN-1:0]  wdata,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic                 alloc_waw
);

    logic [XLEN-1:0] w_regs [NREG];
    logic            w_busy [NREG];

    // ------------------------------------------------------------------
    // Storage: one data word and one busy bit per non-zero register.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign w_regs[i] = '0;
            assign w_busy[i] = 1'b0;
        end else begin : g_live
            logic [XLEN-1:0] r_data;
            logic            r_busy;
            logic            w_wen;
            logic [XLEN-1:0] w_wd;

            // Ascending scan so the highest matching port is the last to
            // assign and therefore wins.
            always_comb begin
                w_wen = 1'b0;
                w_wd  = '0;
                for (int k = 0; k < NWP; k++) begin
                    if (we[k] && (waddr[k*AW +: AW] == AW'(i))) begin
                        w_wen = 1'b1;
                        w_wd  = wdata[k*XLEN +: XLEN];
                    end
                end
            end

            // A same-cycle alloc names a newer producer than the write that
            // is retiring, so setting busy takes precedence over clearing.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data <= '0;
                    r_busy <= 1'b0;
                end else begin
                    if (w_wen) begin
                        r_data <= w_wd;
                    end
                    if (alloc_en && (alloc_addr == AW'(i))) begin
                        r_busy <= 1'b1;
                    end else if (w_wen) begin
                        r_busy <= 1'b0;
                    end
                end
            end

            assign w_regs[i] = r_data;
            assign w_busy[i] = r_busy;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Forwarding and busy reporting are held off during reset
    // so readers see the raw array until the clearing edge.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;

        assign w_ra = raddr[j*AW +: AW];

        ysyx_22041752_rf_bypass #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWP    (NWP),
            .BYPASS (BYPASS)
        ) u_bypass (
            .en       (rst_n),
            .raddr    (w_ra),
            .arr_data (w_regs[w_ra]),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .rdata    (rdata[j*XLEN +: XLEN]),
            .hit      (w_hit)
        );

        // A forwarded write is the pending result, so the reader no longer
        // has to wait on it.
        assign rbusy[j] = rst_n & w_busy[w_ra] & ~w_hit;
    end

    assign alloc_waw = rst_n & alloc_en & w_busy[alloc_addr];

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041752_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22041752_regfile_mp
//  Purpose  : Self-checking bench for the multi-port register file. Drives
//             two instances in lockstep: A (NRD=2, NWP=2, BYPASS=1) and
//             B (NRD=4, NWP=1, BYPASS=0), compared against an array model.
//  Revision : 1.0  initial multi-port release
// ============================================================================
module tb_ysyx_22041752_regfile_mp;

    localparam int XL = 64;
    localparam int AWB = 5;

    logic clk;
    logic rst_n;

    // Per-instance stimulus, sized for the widest instance.
    logic [AWB-1:0] ra    [2][4];
    logic           we_t  [2][2];
    logic [AWB-1:0] wa_t  [2][2];
    logic [XL-1:0]  wd_t  [2][2];
    logic           al_en [2];
    logic [AWB-1:0] al_a  [2];

    // Observed outputs.
    logic [XL-1:0]  o_rd  [2][4];
    logic           o_rb  [2][4];
    logic           o_waw [2];

    int nrd [2] = '{2, 4};
    int nwp [2] = '{2, 1};
    int byp [2] = '{1, 0};

    // Reference model state.
    logic [XL-1:0] m_regs [2][32];
    logic          m_busy [2][32];

    int n_vec = 0;
    int n_bad = 0;

    // DUT buses.
    logic [2*AWB-1:0] raddr_a;  logic [2*XL-1:0] rdata_a;  logic [1:0] rbusy_a;
    logic [1:0]       we_a;     logic [2*AWB-1:0] waddr_a; logic [2*XL-1:0] wdata_a;
    logic             waw_a;
    logic [4*AWB-1:0] raddr_b;  logic [4*XL-1:0] rdata_b;  logic [3:0] rbusy_b;
    logic [0:0]       we_b;     logic [AWB-1:0]   waddr_b; logic [XL-1:0]   wdata_b;
    logic             waw_b;

    always_comb begin
        for (int j = 0; j < 2; j++) raddr_a[j*AWB +: AWB] = ra[0][j];
        for (int j = 0; j < 4; j++) raddr_b[j*AWB +: AWB] = ra[1][j];
        for (int k = 0; k < 2; k++) begin
            we_a[k]               = we_t[0][k];
            waddr_a[k*AWB +: AWB] = wa_t[0][k];
            wdata_a[k*XL +: XL]   = wd_t[0][k];
        end
        we_b[0] = we_t[1][0];
        waddr_b = wa_t[1][0];
        wdata_b = wd_t[1][0];
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            o_rd[0][j] = '0;
            o_rb[0][j] = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            o_rd[0][j] = rdata_a[j*XL +: XL];
            o_rb[0][j] = rbusy_a[j];
        end
        for (int j = 0; j < 4; j++) begin
            o_rd[1][j] = rdata_b[j*XL +: XL];
            o_rb[1][j] = rbusy_b[j];
        end
        o_waw[0] = waw_a;
        o_waw[1] = waw_b;
    end

    ysyx_22041752_regfile_mp #(.NRD(2), .NWP(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .alloc_en(al_en[0]), .alloc_addr(al_a[0]), .alloc_waw(waw_a)
    );

    ysyx_22041752_regfile_mp #(.NRD(4), .NWP(1), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .alloc_en(al_en[1]), .alloc_addr(al_a[1]), .alloc_waw(waw_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference read: zero register, else latest-port forwarding, else array.
    task automatic mread(input int i, input int a, output logic [XL-1:0] d, output logic b);
        int hk;
        hk = -1;
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end else begin
            if (byp[i] == 1 && rst_n) begin
                for (int k = 0; k < nwp[i]; k++)
                    if (we_t[i][k] && int'(wa_t[i][k]) == a) hk = k;
            end
            d = (hk >= 0) ? wd_t[i][hk] : m_regs[i][a];
            b = rst_n && (hk < 0) && m_busy[i][a];
        end
    endtask

    task automatic check_all();
        logic [XL-1:0] d;
        logic          b;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < nrd[i]; j++) begin
                mread(i, int'(ra[i][j]), d, b);
                check($sformatf("rdata[%0d][%0d] a=%0d", i, j, ra[i][j]), o_rd[i][j], d);
                check($sformatf("rbusy[%0d][%0d] a=%0d", i, j, ra[i][j]), {63'd0, o_rb[i][j]}, {63'd0, b});
            end
            b = rst_n && al_en[i] && (al_a[i] != 0) && m_busy[i][al_a[i]];
            check($sformatf("alloc_waw[%0d]", i), {63'd0, o_waw[i]}, {63'd0, b});
        end
    endtask

    // Writes in port order (later overrides earlier), then alloc sets busy.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int a = 0; a < 32; a++) begin
                    m_regs[i][a] = '0;
                    m_busy[i][a] = 1'b0;
                end
            end else begin
                for (int k = 0; k < nwp[i]; k++) begin
                    if (we_t[i][k] && wa_t[i][k] != 0) begin
                        m_regs[i][wa_t[i][k]] = wd_t[i][k];
                        m_busy[i][wa_t[i][k]] = 1'b0;
                    end
                end
                if (al_en[i] && al_a[i] != 0) m_busy[i][al_a[i]] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) ra[i][j] = '0;
            for (int k = 0; k < 2; k++) begin
                we_t[i][k] = 1'b0;
                wa_t[i][k] = '0;
                wd_t[i][k] = '0;
            end
            al_en[i] = 1'b0;
            al_a[i]  = '0;
        end
    endtask

    task automatic wr(input int k, input logic [AWB-1:0] a, input logic [XL-1:0] d);
        for (int i = 0; i < 2; i++) begin
            if (k < nwp[i]) begin
                we_t[i][k] = 1'b1;
                wa_t[i][k] = a;
                wd_t[i][k] = d;
            end
        end
    endtask

    task automatic rd(input int j, input logic [AWB-1:0] a);
        for (int i = 0; i < 2; i++)
            if (j < nrd[i]) ra[i][j] = a;
    endtask

    task automatic al(input logic [AWB-1:0] a);
        for (int i = 0; i < 2; i++) begin
            al_en[i] = 1'b1;
            al_a[i]  = a;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++) begin
                m_regs[i][a] = '0;
                m_busy[i][a] = 1'b0;
            end
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step();

        // 1: everything reads zero / not busy after reset.
        idle();
        for (int a = 0; a < 32; a++) begin
            for (int j = 0; j < 4; j++) rd(j, AWB'(a));
            #1;
            check("t1 rdata A", o_rd[0][1], 64'd0);
            check("t1 rbusy B", {63'd0, o_rb[1][3]}, 64'd0);
            step();
        end

        // 2: write then read; write to register 0 is dropped.
        idle(); wr(0, 5'd5, 64'hDEAD); step();
        idle(); rd(0, 5'd5); #1;
        check("t2 rd5 A", o_rd[0][0], 64'hDEAD);
        check("t2 rd5 B", o_rd[1][0], 64'hDEAD);
        step();
        idle(); wr(0, 5'd0, 64'd1); rd(0, 5'd0); step();
        idle(); rd(0, 5'd0); #1;
        check("t2 rd0 A", o_rd[0][0], 64'd0);
        step();

        // 3: both ports hit 7; port 1 wins, also through the bypass.
        idle(); wr(0, 5'd7, 64'd1); wr(1, 5'd7, 64'd2); rd(0, 5'd7); #1;
        check("t3 bypass A", o_rd[0][0], 64'd2);
        check("t3 nobypass B", o_rd[1][0], 64'd0);
        step();
        idle(); rd(0, 5'd7); #1;
        check("t3 reg7 A", o_rd[0][0], 64'd2);
        check("t3 reg7 B", o_rd[1][0], 64'd1);
        step();

        // 4: alloc 9, re-alloc flags WAW, write clears busy.
        idle(); al(5'd9); step();
        idle(); rd(1, 5'd9); al(5'd9); #1;
        check("t4 rbusy A", {63'd0, o_rb[0][1]}, 64'd1);
        check("t4 waw A", {63'd0, o_waw[0]}, 64'd1);
        check("t4 waw B", {63'd0, o_waw[1]}, 64'd1);
        step();
        idle(); wr(0, 5'd9, 64'h99); rd(1, 5'd9); #1;
        check("t4 wr-bypass rbusy A", {63'd0, o_rb[0][1]}, 64'd0);
        check("t4 wr rbusy B", {63'd0, o_rb[1][1]}, 64'd1);
        step();
        idle(); rd(1, 5'd9); #1;
        check("t4 cleared A", {63'd0, o_rb[0][1]}, 64'd0);
        check("t4 cleared B", {63'd0, o_rb[1][1]}, 64'd0);
        step();

        // 5: alloc and write same register: data lands, busy stays set.
        idle(); al(5'd3); wr(0, 5'd3, 64'h33); step();
        idle(); rd(0, 5'd3); #1;
        check("t5 busy A", {63'd0, o_rb[0][0]}, 64'd1);
        check("t5 data B", o_rd[1][0], 64'h33);
        step();

        // 6: reset with writes/alloc active; bypass and busy suppressed.
        idle(); wr(0, 5'd12, 64'hC0FFEE); al(5'd13); step();
        idle(); rst_n = 1'b0; wr(0, 5'd12, 64'h1234); wr(1, 5'd12, 64'h5678);
        al(5'd12); rd(0, 5'd12); rd(1, 5'd13); #1;
        check("t6 rst rdata A", o_rd[0][0], 64'hC0FFEE);
        check("t6 rst rbusy A", {63'd0, o_rb[0][1]}, 64'd0);
        check("t6 rst waw A", {63'd0, o_waw[0]}, 64'd0);
        step();
        idle();
        for (int a = 0; a < 32; a += 4) begin
            for (int j = 0; j < 4; j++) rd(j, AWB'(a + j));
            step();
        end

        // Random traffic with a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst_n = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < nrd[i]; j++) ra[i][j] = AWB'($urandom_range(0, 7));
                for (int k = 0; k < nwp[i]; k++) begin
                    we_t[i][k] = $urandom_range(0, 1) == 1;
                    wa_t[i][k] = AWB'($urandom_range(0, 7));
                    wd_t[i][k] = {$urandom, $urandom};
                end
                al_en[i] = $urandom_range(0, 2) == 0;
                al_a[i]  = AWB'($urandom_range(0, 7));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
